cond_ctrl: RTL

Condition-flag controller that sequences writes to the 4-bit condition register and decides when flag consumers may proceed. Sits beside decode/execute in the pipeline. Tracks in-flight flag-setting instructions issued from decode and stalls conditional instructions until their flags are architecturally current. Commits ALU flags into the register when a flag-setter retires from execute.

---
 rtl/cond_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/cond_ctrl.sv
// Condition-flag controller: tracks in-flight flag setters, stalls flag readers and commits ALU flags.
// Optional macro COND_FWD_EN lets a reader take the retiring setter's flags in the same cycle.
module cond_ctrl #(
    parameter int FLAG_W = 4,
    parameter int MAX_INFLIGHT = 3,
    parameter logic [FLAG_W-1:0] RESET_COND = 4'b1110,
    parameter int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_set_cond,
    input  logic              id_use_cond,
    input  logic              ex_done,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flush,
    output logic              stall,
    output logic [FLAG_W-1:0] read_cond,
    output logic [FLAG_W-1:0] cond,
    output logic [CW-1:0]     pending,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] maxCount = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] oneCount = CW'(1);

    state_t        state;
    logic          fwdHit;
    logic          readHazard;
    logic          fullHazard;
    logic          setterAccepted;
    logic          retire;
    logic          protoErr;
    logic [CW-1:0] nextPending;

    // IDLE is kept equivalent to an empty counter, so the state doubles as the "nothing in flight" test.
    always_comb begin
        fwdHit = 1'b0;
`ifdef COND_FWD_EN
        fwdHit = (pending == oneCount) && ex_done && !flush;
`endif
        readHazard = id_valid && id_use_cond && (state != IDLE) && !fwdHit;
        fullHazard = id_valid && id_set_cond && (pending == maxCount) && !ex_done;
        stall = !flush && (readHazard || fullHazard);
        read_cond = fwdHit ? alu_flags : cond;
        setterAccepted = id_valid && id_set_cond && !stall && !flush;
        retire = ex_done && (state != IDLE);
        protoErr = ex_done && (state == IDLE);
        nextPending = pending;
        if (flush) begin
            nextPending = '0;
        end else if (setterAccepted && !retire) begin
            nextPending = pending + oneCount;
        end else if (retire && !setterAccepted) begin
            nextPending = pending - oneCount;
        end
    end

    // Flush only squashes younger setters; an ex_done in the same cycle is older and still commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond    <= RESET_COND;
            pending <= '0;
            err     <= 1'b0;
            state   <= IDLE;
        end else begin
            pending <= nextPending;
            if (retire) begin
                cond <= alu_flags;
            end
            if (protoErr) begin
                err <= 1'b1;
            end
            if (nextPending == '0) begin
                state <= IDLE;
            end else if (stall) begin
                state <= HOLD;
            end else begin
                state <= BUSY;
            end
        end
    end

endmodule
